// File: rtl/ln_vec_feeder.sv
// ln_vec_feeder: streams one token vector into the layer-norm vector engine.
// On an accepted start it presents data_num and the in/out scale positions for one cycle. It then
// reads one activation word and one gamma/beta word per cycle from the SRAMs and forwards them
// BUS_NUM lanes per beat. Lanes past data_num on the last beat are masked to zero.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, cmd_*               command pulse and its fields (sampled only when idle)
//   act_rd_*, prm_rd_*         SRAM read ports (data returns RD_LAT cycles after enable)
//   gamma_rd_data/beta_rd_data parameter SRAM read data
//   ln_*                       layer-norm engine config and data bus (all registered)
//   busy, done                 command status
module ln_vec_feeder #(
  parameter int unsigned BUS_NUM         = 8,
  parameter int unsigned DATA_NUM_WIDTH  = 10,
  parameter int unsigned SCALA_POS_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned RD_LAT          = 1,
  parameter int unsigned sig_width       = 7,
  parameter int unsigned exp_width       = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [DATA_NUM_WIDTH-1:0]                     cmd_data_num,
  input  logic [SCALA_POS_WIDTH-1:0]                    cmd_in_scale_pos,
  input  logic [SCALA_POS_WIDTH-1:0]                    cmd_out_scale_pos,
  input  logic [ADDR_WIDTH-1:0]                         cmd_act_base,
  input  logic [ADDR_WIDTH-1:0]                         cmd_prm_base,
  output logic                                          act_rd_en,
  output logic [ADDR_WIDTH-1:0]                         act_rd_addr,
  input  logic [BUS_NUM*8-1:0]                          act_rd_data,
  output logic                                          prm_rd_en,
  output logic [ADDR_WIDTH-1:0]                         prm_rd_addr,
  input  logic [BUS_NUM*(sig_width+exp_width+1)-1:0]    gamma_rd_data,
  input  logic [BUS_NUM*(sig_width+exp_width+1)-1:0]    beta_rd_data,
  output logic [DATA_NUM_WIDTH-1:0]                     ln_data_num,
  output logic                                          ln_data_num_vld,
  output logic [SCALA_POS_WIDTH-1:0]                    ln_in_scale_pos,
  output logic                                          ln_in_scale_pos_vld,
  output logic [SCALA_POS_WIDTH-1:0]                    ln_out_scale_pos,
  output logic                                          ln_out_scale_pos_vld,
  output logic [BUS_NUM*8-1:0]                          ln_fixed_data,
  output logic [BUS_NUM-1:0]                            ln_fixed_data_vld,
  output logic [BUS_NUM*(sig_width+exp_width+1)-1:0]    ln_gamma,
  output logic [BUS_NUM-1:0]                            ln_gamma_vld,
  output logic [BUS_NUM*(sig_width+exp_width+1)-1:0]    ln_beta,
  output logic [BUS_NUM-1:0]                            ln_beta_vld,
  output logic                                          busy,
  output logic                                          done
);
  localparam int unsigned FW    = sig_width + exp_width + 1;
  localparam int unsigned LgBus = $clog2(BUS_NUM);

  typedef enum logic [1:0] {StIdle, StCfg, StStream, StDrain} state_e;

  state_e                      state_q, state_d;
  logic                        busy_q, busy_d, done_q, done_d, cfg_vld_q, cfg_vld_d;
  logic [DATA_NUM_WIDTH-1:0]   num_q, num_d, cnt_q, cnt_d, ln_num_q, ln_num_d;
  logic [SCALA_POS_WIDTH-1:0]  in_sp_q, in_sp_d, out_sp_q, out_sp_d;
  logic [ADDR_WIDTH-1:0]       act_addr_q, act_addr_d, prm_addr_q, prm_addr_d;
  logic                        rd_en_q, rd_en_d;
  // Stage 0 is the mask of the beat being read this cycle; stage RD_LAT lines up with its data.
  logic [BUS_NUM-1:0]          pipe_q [RD_LAT+1];
  logic [BUS_NUM-1:0]          pipe_d [RD_LAT+1];
  logic [BUS_NUM*8-1:0]        data_q, data_d;
  logic [BUS_NUM*FW-1:0]       gamma_q, gamma_d, beta_q, beta_d;
  logic [BUS_NUM-1:0]          vld_q, vld_d;

  logic [DATA_NUM_WIDTH-1:0]   beats;
  logic [LgBus-1:0]            rem;
  logic [BUS_NUM-1:0]          last_mask, issue_mask, out_mask;
  logic                        pending;

  assign rem   = num_q[LgBus-1:0];
  assign beats = (num_q >> LgBus) + DATA_NUM_WIDTH'(rem != '0);

  always_comb begin
    last_mask = '0;
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      last_mask[i] = (rem == '0) || (i < 32'(rem));
    end
    pending = 1'b0;
    for (int unsigned i = 0; i <= RD_LAT; i++) begin
      pending = pending | (|pipe_q[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_vld_d  = 1'b0;
    ln_num_d   = '0;
    num_d      = num_q;
    in_sp_d    = in_sp_q;
    out_sp_d   = out_sp_q;
    cnt_d      = cnt_q;
    act_addr_d = act_addr_q;
    prm_addr_d = prm_addr_q;
    rd_en_d    = 1'b0;
    issue_mask = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d      = cmd_data_num;
          in_sp_d    = cmd_in_scale_pos;
          out_sp_d   = cmd_out_scale_pos;
          act_addr_d = cmd_act_base;
          prm_addr_d = cmd_prm_base;
          cnt_d      = '0;
          cfg_vld_d  = 1'b1;
          ln_num_d   = cmd_data_num;
          busy_d     = 1'b1;
          state_d    = StCfg;
        end
      end
      StCfg: begin
        if (beats == '0) begin
          // Nothing to stream: finish straight from config.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDrain;
        end else begin
          rd_en_d    = 1'b1;
          cnt_d      = DATA_NUM_WIDTH'(1);
          issue_mask = (beats == DATA_NUM_WIDTH'(1)) ? last_mask : '1;
          state_d    = StStream;
        end
      end
      StStream: begin
        if (cnt_q < beats) begin
          rd_en_d    = 1'b1;
          act_addr_d = act_addr_q + ADDR_WIDTH'(1);
          prm_addr_d = prm_addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q + DATA_NUM_WIDTH'(1);
          issue_mask = (cnt_d == beats) ? last_mask : '1;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (done_q) begin
          state_d = StIdle;
        end else if (!pending) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_d[0] = issue_mask;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    out_mask = pipe_q[RD_LAT];
    vld_d    = out_mask;
    data_d   = '0;
    gamma_d  = '0;
    beta_d   = '0;
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      if (out_mask[i]) begin
        data_d[i*8 +: 8]   = act_rd_data[i*8 +: 8];
        gamma_d[i*FW +: FW] = gamma_rd_data[i*FW +: FW];
        beta_d[i*FW +: FW]  = beta_rd_data[i*FW +: FW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_vld_q  <= 1'b0;
      ln_num_q   <= '0;
      num_q      <= '0;
      in_sp_q    <= '0;
      out_sp_q   <= '0;
      cnt_q      <= '0;
      act_addr_q <= '0;
      prm_addr_q <= '0;
      rd_en_q    <= 1'b0;
      for (int unsigned i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
      data_q     <= '0;
      gamma_q    <= '0;
      beta_q     <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_vld_q  <= cfg_vld_d;
      ln_num_q   <= ln_num_d;
      num_q      <= num_d;
      in_sp_q    <= in_sp_d;
      out_sp_q   <= out_sp_d;
      cnt_q      <= cnt_d;
      act_addr_q <= act_addr_d;
      prm_addr_q <= prm_addr_d;
      rd_en_q    <= rd_en_d;
      for (int unsigned i = 0; i <= RD_LAT; i++) pipe_q[i] <= pipe_d[i];
      data_q     <= data_d;
      gamma_q    <= gamma_d;
      beta_q     <= beta_d;
      vld_q      <= vld_d;
    end
  end

  // Scale positions are only driven alongside their valid pulse.
  logic [SCALA_POS_WIDTH-1:0] ln_in_q, ln_out_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ln_in_q  <= '0;
      ln_out_q <= '0;
    end else begin
      ln_in_q  <= cfg_vld_d ? in_sp_d : '0;
      ln_out_q <= cfg_vld_d ? out_sp_d : '0;
    end
  end

  assign act_rd_en            = rd_en_q;
  assign prm_rd_en            = rd_en_q;
  assign act_rd_addr          = act_addr_q;
  assign prm_rd_addr          = prm_addr_q;
  assign ln_data_num          = ln_num_q;
  assign ln_data_num_vld      = cfg_vld_q;
  assign ln_in_scale_pos      = ln_in_q;
  assign ln_in_scale_pos_vld  = cfg_vld_q;
  assign ln_out_scale_pos     = ln_out_q;
  assign ln_out_scale_pos_vld = cfg_vld_q;
  assign ln_fixed_data        = data_q;
  assign ln_fixed_data_vld    = vld_q;
  assign ln_gamma             = gamma_q;
  assign ln_gamma_vld         = vld_q;
  assign ln_beta              = beta_q;
  assign ln_beta_vld          = vld_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_ln_vec_feeder.sv
// Bench for ln_vec_feeder: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3. Each command's
// expected cycle-by-cycle trace comes from a timeline model built from beat counts and latencies.
module tb_ln_vec_feeder;
  logic clk, rst_n;

  logic         start     [2];
  logic [9:0]   cmd_num   [2];
  logic [4:0]   cmd_isp   [2];
  logic [4:0]   cmd_osp   [2];
  logic [7:0]   cmd_ab    [2];
  logic [7:0]   cmd_pb    [2];
  logic         act_en    [2];
  logic [7:0]   act_addr  [2];
  logic [63:0]  act_data  [2];
  logic         prm_en    [2];
  logic [7:0]   prm_addr  [2];
  logic [127:0] gam_data  [2];
  logic [127:0] bet_data  [2];
  logic [9:0]   o_num     [2];
  logic         o_num_vld [2];
  logic [4:0]   o_isp     [2];
  logic         o_isp_vld [2];
  logic [4:0]   o_osp     [2];
  logic         o_osp_vld [2];
  logic [63:0]  o_data    [2];
  logic [7:0]   o_dvld    [2];
  logic [127:0] o_gam     [2];
  logic [7:0]   o_gvld    [2];
  logic [127:0] o_bet     [2];
  logic [7:0]   o_bvld    [2];
  logic         o_busy    [2];
  logic         o_done    [2];

  logic [63:0]  act_mem [256];
  logic [127:0] gam_mem [256];
  logic [127:0] bet_mem [256];
  logic [7:0]   a_sh [2][3];
  logic [7:0]   p_sh [2][3];

  int checks, failures;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ln_vec_feeder #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]),
      .cmd_data_num(cmd_num[g]), .cmd_in_scale_pos(cmd_isp[g]), .cmd_out_scale_pos(cmd_osp[g]),
      .cmd_act_base(cmd_ab[g]), .cmd_prm_base(cmd_pb[g]),
      .act_rd_en(act_en[g]), .act_rd_addr(act_addr[g]), .act_rd_data(act_data[g]),
      .prm_rd_en(prm_en[g]), .prm_rd_addr(prm_addr[g]),
      .gamma_rd_data(gam_data[g]), .beta_rd_data(bet_data[g]),
      .ln_data_num(o_num[g]), .ln_data_num_vld(o_num_vld[g]),
      .ln_in_scale_pos(o_isp[g]), .ln_in_scale_pos_vld(o_isp_vld[g]),
      .ln_out_scale_pos(o_osp[g]), .ln_out_scale_pos_vld(o_osp_vld[g]),
      .ln_fixed_data(o_data[g]), .ln_fixed_data_vld(o_dvld[g]),
      .ln_gamma(o_gam[g]), .ln_gamma_vld(o_gvld[g]),
      .ln_beta(o_bet[g]), .ln_beta_vld(o_bvld[g]),
      .busy(o_busy[g]), .done(o_done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: read data appears a fixed number of cycles after the address is presented.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      a_sh[d][0] <= act_addr[d];
      p_sh[d][0] <= prm_addr[d];
      for (int i = 1; i < 3; i++) begin
        a_sh[d][i] <= a_sh[d][i-1];
        p_sh[d][i] <= p_sh[d][i-1];
      end
    end
  end

  always_comb begin
    act_data[0] = act_mem[a_sh[0][0]];
    gam_data[0] = gam_mem[p_sh[0][0]];
    bet_data[0] = bet_mem[p_sh[0][0]];
    act_data[1] = act_mem[a_sh[1][2]];
    gam_data[1] = gam_mem[p_sh[1][2]];
    bet_data[1] = bet_mem[p_sh[1][2]];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat_mask(input int k, input int nbeats, input int rem);
    int n;
    n = (k == nbeats - 1 && rem != 0) ? rem : 8;
    beat_mask = '0;
    for (int i = 0; i < n; i++) beat_mask[i] = 1'b1;
  endfunction

  function automatic logic [63:0] pick8(input logic [63:0] w, input logic [7:0] m);
    pick8 = '0;
    for (int i = 0; i < 8; i++) if (m[i]) pick8[i*8 +: 8] = w[i*8 +: 8];
  endfunction

  function automatic logic [127:0] pick16(input logic [127:0] w, input logic [7:0] m);
    pick16 = '0;
    for (int i = 0; i < 8; i++) if (m[i]) pick16[i*16 +: 16] = w[i*16 +: 16];
  endfunction

  function automatic logic [255:0] all_outs(input int d);
    all_outs = {act_en[d], act_addr[d], prm_en[d], prm_addr[d], o_num[d], o_num_vld[d],
                o_isp[d], o_isp_vld[d], o_osp[d], o_osp_vld[d], o_dvld[d], o_gvld[d],
                o_bvld[d], o_busy[d], o_done[d], o_data[d][63:0]};
  endfunction

  function automatic logic [255:0] wide_outs(input int d);
    wide_outs = {o_gam[d], o_bet[d]};
  endfunction

  // Issue a command on instance d at the current negedge and check the whole trace.
  // inject_at: cycle at which a conflicting start is pulsed; abort_at: cycle at which reset hits.
  task automatic run(input int d, input int num, input logic [7:0] ab, input logic [7:0] pb,
                     input logic [4:0] isp, input logic [4:0] osp,
                     input int inject_at, input int abort_at);
    int lat, nbeats, rem, done_n, kb;
    logic [7:0] m, a, p;
    lat    = (d == 0) ? 1 : 3;
    nbeats = (num + 7) / 8;
    rem    = num % 8;
    done_n = (nbeats == 0) ? 1 : nbeats + lat + 2;
    cmd_num[d] = 10'(num);
    cmd_ab[d]  = ab;
    cmd_pb[d]  = pb;
    cmd_isp[d] = isp;
    cmd_osp[d] = osp;
    start[d]   = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= done_n + 2; n++) begin
      @(negedge clk);
      chk("ctrl", {o_busy[d], o_done[d], o_num_vld[d], o_isp_vld[d], o_osp_vld[d],
                   o_num[d], o_isp[d], o_osp[d]},
          {n < done_n, n == done_n, {3{n == 0}},
           (n == 0) ? 10'(num) : 10'd0, (n == 0) ? isp : 5'd0, (n == 0) ? osp : 5'd0});
      chk("rd_en", {act_en[d], prm_en[d]}, {2{n >= 1 && n <= nbeats}});
      if (n >= 1 && n <= nbeats) begin
        a = ab + 8'(n - 1);
        p = pb + 8'(n - 1);
        chk("rd_addr", {act_addr[d], prm_addr[d]}, {a, p});
      end
      kb = n - lat - 2;
      m  = (kb >= 0 && kb < nbeats) ? beat_mask(kb, nbeats, rem) : 8'h00;
      a  = ab + 8'(kb);
      p  = pb + 8'(kb);
      chk("vld", {o_dvld[d], o_gvld[d], o_bvld[d]}, {m, m, m});
      chk("data", o_data[d], pick8(act_mem[a], m));
      chk("gamma", o_gam[d], pick16(gam_mem[p], m));
      chk("beta", o_bet[d], pick16(bet_mem[p], m));
      start[d] = (n == inject_at);
      if (n == inject_at) begin
        cmd_num[d] = 10'(num + 9);
        cmd_ab[d]  = ab + 8'h33;
        cmd_isp[d] = ~isp;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", all_outs(d), '0);
        chk("abort_wide", wide_outs(d), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", {o_done[d], o_busy[d]}, 2'b00);
        return;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = {$urandom, $urandom};
      gam_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      bet_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d]   = 1'b0;
      cmd_num[d] = '0;
      cmd_isp[d] = '0;
      cmd_osp[d] = '0;
      cmd_ab[d]  = '0;
      cmd_pb[d]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outs", all_outs(d), '0);
      chk("reset_wide", wide_outs(d), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 16, 8'h10, 8'h40, 5'h03, 5'h1D, -1, -1);
    run(0, 13, 8'h20, 8'h50, 5'h1F, 5'h01, -1, -1);
    run(0, 0,  8'h30, 8'h60, 5'h05, 5'h06, -1, -1);
    run(0, 20, 8'h40, 8'h70, 5'h0A, 5'h15, 2, -1);
    run(0, 40, 8'h50, 8'h80, 5'h02, 5'h04, -1, 3);
    run(0, 16, 8'h10, 8'h40, 5'h07, 5'h08, -1, -1);
    run(0, 24, 8'hFF, 8'hFE, 5'h11, 5'h12, -1, -1);
    run(1, 24, 8'hFF, 8'hFE, 5'h13, 5'h14, -1, -1);
    run(1, 13, 8'h05, 8'h06, 5'h09, 5'h0B, -1, -1);
    run(1, 0,  8'h07, 8'h08, 5'h0C, 5'h0D, 1, -1);
    for (int r = 0; r < 12; r++) begin
      run(r % 2, int'($urandom_range(0, 60)), 8'($urandom), 8'($urandom),
          5'($urandom), 5'($urandom), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
